burst_requester: RTL and testbench
==================================

BURST_REQUESTER -- requirements
Module: burst_requester

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the rising-edge clock for all state.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and be the asynchronous active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide, and request a burst (sampled in IDLE only).
REQ-005 Port len SHALL be an input, 4 bits wide, and give the number of strobes requested (1..15), sampled with start.
REQ-006 Port s SHALL be an input, 1 bit wide, and carry the per-cycle strobe from the transmitter.
REQ-007 Port g SHALL be an input, 1 bit wide, and carry the end-of-burst pulse from the transmitter.
REQ-008 Port do SHALL be an output, 1 bit wide, and be the burst request to the transmitter (registered; do = state==REQ).
REQ-009 Port busy SHALL be an output, 1 bit wide, and be 1 in every state except IDLE.
REQ-010 Port done SHALL be an output, 1 bit wide, and be a one-cycle completion pulse (1 in GAP).
REQ-011 Port err SHALL be an output, 1 bit wide, and be a sticky protocol-error flag, valid while done=1 and held until the next accepted start.
REQ-012 Port cnt SHALL be an output, 4 bits wide, and hold the strobes counted in the current or last burst.

Function
REQ-013 The FSM SHALL have exactly 4 states: IDLE, REQ, END, GAP. Any illegal encoding SHALL go to IDLE on the next clock.
REQ-014 IDLE: if start=1 and len!=0, the block SHALL latch len into len_q, load rem=len, clear cnt and err, and go to REQ.
REQ-015 IDLE: if start=1 and len==0, the block SHALL ignore the request, with no state or output change. start in any other state SHALL be ignored.
REQ-016 REQ: do=1. If rem==0, go to END; otherwise rem decrements by 1. REQ therefore SHALL last len_q+1 cycles.
REQ-017 The transmitter strobes s starting on the 2nd REQ cycle, so the expected strobe count SHALL be exactly len_q.
REQ-018 cnt SHALL increment on each cycle with s=1 in REQ or END, and SHALL saturate at 15 without wrapping.
REQ-019 END: do=0 and the transmitter must assert g in this cycle. err SHALL be set if g=0, or if the post-increment cnt != len_q. The FSM SHALL go unconditionally to GAP.
REQ-020 GAP: lasts one cycle (transmitter settling LAST->IDLE), do=0, done=1, then IDLE.
REQ-021 Protocol errors SHALL set err: s=1 or g=1 in IDLE or GAP; g=1 in REQ. The FSM sequence SHALL NOT change because of these errors.
REQ-022 When err is set and cleared in the same cycle (start accepted), clear SHALL win.
REQ-023 The request-to-done latency for len=N SHALL be N+3 cycles, counted from the start cycle to the done cycle.

Reset
REQ-024 When rst_n=0, the block SHALL immediately force state=IDLE, do=0, busy=0, done=0, err=0, cnt=0, rem=0, len_q=0, regardless of the clock.
REQ-025 A reset mid-burst SHALL drop do in the same cycle. The first post-reset burst SHALL behave per REQ-014.

Verification
REQ-026 Nominal burst: start, len=3; s high on cycles 2-4 after start; g on cycle 5 -> do high on cycles 1-4, done on cycle 6, cnt=3, err=0.
REQ-027 Minimum burst: len=1 with a compliant transmitter -> do high for 2 cycles, one s strobe, done 4 cycles after start, cnt=1, err=0.
REQ-028 Missing g: len=2, g held 0 -> done asserted on schedule, err=1, cnt=2, and the next start clears err.
REQ-029 Count mismatch and stray strobes: len=4 with only 3 strobes -> err=1. A separate run with an s pulse in IDLE -> err=1, and the FSM does not leave IDLE without start.
REQ-030 Ignored starts: start with len=0 -> busy stays 0. start asserted during REQ -> no effect on rem or len_q.
REQ-031 Mid-burst reset: rst_n low during the REQ cycle with rem=1 -> do, busy and cnt are 0 immediately. A burst with len=2 after release completes with cnt=2 and err=0.

Source files
------------

// File: rtl/burst_requester_if.sv
// ---------------------------------------------------------------------------
// burst_requester_if
//   Groups the burst handshake between a controller, the burst_requester and
//   the transmitter it drives.
//
//   start  : request a burst (only looked at while the requester is idle)
//   len    : number of strobes requested, 1..15, captured together with start
//   s      : per-cycle strobe from the transmitter
//   g      : end-of-burst pulse from the transmitter
//   do_o   : burst request to the transmitter (high while in REQ)
//   busy   : requester is not idle
//   done   : one-cycle completion pulse
//   err    : sticky protocol-error flag, valid with done, held until next start
//   cnt    : strobes counted in the current or last burst
//
//   slave  : the burst_requester side
//   master : the controller / transmitter / testbench side
// ---------------------------------------------------------------------------
interface burst_requester_if;
    logic       start;
    logic [3:0] len;
    logic       s;
    logic       g;
    logic       do_o;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] cnt;

    modport slave (
        input  start, len, s, g,
        output do_o, busy, done, err, cnt
    );

    modport master (
        output start, len, s, g,
        input  do_o, busy, done, err, cnt
    );
endinterface

// File: rtl/burst_requester.sv
// ---------------------------------------------------------------------------
// burst_requester
//   Issues a burst request to a transmitter, counts the strobes it returns and
//   flags protocol violations. Sequence per accepted request of length N:
//   IDLE -> REQ (N+1 cycles) -> END (1 cycle, g expected) -> GAP (done) -> IDLE
//
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : burst_requester_if.slave (start/len/s/g in, do_o/busy/done/err/cnt out)
// ---------------------------------------------------------------------------
module burst_requester (
    input  logic               clk,
    input  logic               rst_n,
    burst_requester_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_END  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] rem_q,   rem_d;
    logic [3:0] len_q,   len_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       err_q,   err_d;

    logic [3:0] cnt_inc;
    logic [3:0] cnt_end;

    // NOTE: every signal gets its hold value before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_end = cnt_q;

        // Strobe counter saturates at 15 rather than wrapping.
        cnt_inc = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                // Transmitter must be quiet while no burst is in flight.
                if (bus.s || bus.g) begin
                    err_d = 1'b1;
                end
                // Accepting a request clears err; listed last so clear wins.
                if (bus.start && (bus.len != 4'd0)) begin
                    len_d   = bus.len;
                    rem_d   = bus.len;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (bus.s) begin
                    cnt_d = cnt_inc;
                end
                if (bus.g) begin
                    err_d = 1'b1;
                end
                // rem starts at len, so REQ lasts len+1 cycles.
                if (rem_q == 4'd0) begin
                    state_d = ST_END;
                end else begin
                    rem_d = rem_q - 4'd1;
                end
            end

            ST_END: begin
                // Compare against the count including this cycle's strobe.
                cnt_end = bus.s ? cnt_inc : cnt_q;
                cnt_d   = cnt_end;
                if (!bus.g || (cnt_end != len_q)) begin
                    err_d = 1'b1;
                end
                state_d = ST_GAP;
            end

            ST_GAP: begin
                if (bus.s || bus.g) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= 4'd0;
            len_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from flops, so reset removes them immediately.
    assign bus.do_o = (state_q == ST_REQ);
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_GAP);
    assign bus.err  = err_q;
    assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_burst_requester.sv
// ---------------------------------------------------------------------------
// tb_burst_requester
//   Directed scenarios followed by randomized bursts. Expected values come from
//   a per-burst model: do is high for cycles 1..N+1 after start, done on cycle
//   N+3, cnt is the saturated number of strobes in cycles 1..N+2, and err is
//   any missing g, count mismatch or stray pulse.
// ---------------------------------------------------------------------------
module tb_burst_requester;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    burst_requester_if bus ();

    burst_requester dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Strobes of a compliant transmitter: REQ cycles 2..n+1.
    function automatic logic [17:0] compliant(input int n);
        logic [17:0] p;
        p = '0;
        for (int k = 2; k <= n + 1; k++) p[k] = 1'b1;
        return p;
    endfunction

    // One burst of length n. s_pat[k] / g_req_pat[k] drive cycle k after start.
    task automatic run_burst(input int n, input logic [17:0] s_pat, input logic g_end,
                             input logic [17:0] g_req_pat, input logic gap_stray,
                             input logic start_in_req);
        int         strobes;
        logic [3:0] e_cnt;
        logic       e_err;

        strobes = 0;
        for (int k = 1; k <= n + 2; k++) strobes += int'(s_pat[k]);
        e_cnt = (strobes > 15) ? 4'd15 : 4'(strobes);
        e_err = !g_end || (e_cnt != 4'(n));
        for (int k = 1; k <= n + 1; k++) if (g_req_pat[k]) e_err = 1'b1;

        bus.start = 1'b1;
        bus.len   = 4'(n);
        bus.s     = 1'b0;
        bus.g     = 1'b0;
        @(negedge clk);
        chk("start_busy", {3'b0, bus.busy}, 4'd0);
        chk("start_do",   {3'b0, bus.do_o}, 4'd0);
        next_cycle();

        for (int k = 1; k <= n + 3; k++) begin
            bus.start = start_in_req && (k <= n + 1);
            bus.len   = 4'($urandom_range(1, 15));
            bus.s     = (k <= n + 2) ? s_pat[k] : gap_stray;
            bus.g     = (k <= n + 1) ? g_req_pat[k] : ((k == n + 2) ? g_end : 1'b0);
            @(negedge clk);
            chk("do",   {3'b0, bus.do_o}, {3'b0, (k <= n + 1)});
            chk("busy", {3'b0, bus.busy}, 4'd1);
            chk("done", {3'b0, bus.done}, {3'b0, (k == n + 3)});
            if (k == 1) begin
                chk("cnt_cleared", bus.cnt, 4'd0);
                chk("err_cleared", {3'b0, bus.err}, 4'd0);
            end
            if (k == n + 3) begin
                chk("cnt_at_done", bus.cnt, e_cnt);
                chk("err_at_done", {3'b0, bus.err}, {3'b0, e_err});
            end
            next_cycle();
        end

        bus.start = 1'b0;
        bus.s     = 1'b0;
        bus.g     = 1'b0;
        @(negedge clk);
        chk("idle_busy", {3'b0, bus.busy}, 4'd0);
        chk("idle_done", {3'b0, bus.done}, 4'd0);
        chk("idle_cnt",  bus.cnt, e_cnt);
        chk("idle_err",  {3'b0, bus.err}, {3'b0, (e_err | gap_stray)});
        next_cycle();
    endtask

    initial begin
        logic [17:0] sp;
        logic [17:0] gp;
        int          n;

        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.len   = 4'd0;
        bus.s     = 1'b0;
        bus.g     = 1'b0;

        // Reset state.
        #12;
        chk("rst_do",   {3'b0, bus.do_o}, 4'd0);
        chk("rst_busy", {3'b0, bus.busy}, 4'd0);
        chk("rst_done", {3'b0, bus.done}, 4'd0);
        chk("rst_err",  {3'b0, bus.err},  4'd0);
        chk("rst_cnt",  bus.cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Nominal, minimum, saturation at 15 strobes.
        run_burst(3, compliant(3), 1'b1, '0, 1'b0, 1'b0);
        run_burst(1, compliant(1), 1'b1, '0, 1'b0, 1'b0);
        run_burst(15, 18'h3fffe, 1'b1, '0, 1'b0, 1'b0);

        // Missing g, then the next start clears err.
        run_burst(2, compliant(2), 1'b0, '0, 1'b0, 1'b0);
        run_burst(2, compliant(2), 1'b1, '0, 1'b0, 1'b0);

        // Count mismatch: len=4 with only 3 strobes.
        run_burst(4, compliant(3), 1'b1, '0, 1'b0, 1'b0);

        // g during REQ, stray s in GAP, start during REQ.
        run_burst(3, compliant(3), 1'b1, 18'b100, 1'b0, 1'b0);
        run_burst(3, compliant(3), 1'b1, '0, 1'b1, 1'b0);
        run_burst(5, compliant(5), 1'b1, '0, 1'b0, 1'b1);

        // Clean burst, then a stray s pulse in IDLE.
        run_burst(2, compliant(2), 1'b1, '0, 1'b0, 1'b0);
        bus.s = 1'b1;
        next_cycle();
        bus.s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_err",  {3'b0, bus.err},  4'd1);
            chk("stray_busy", {3'b0, bus.busy}, 4'd0);
            next_cycle();
        end

        // start with len=0 is ignored.
        bus.start = 1'b1;
        bus.len   = 4'd0;
        next_cycle();
        bus.start = 1'b0;
        @(negedge clk);
        chk("len0_busy", {3'b0, bus.busy}, 4'd0);
        chk("len0_err",  {3'b0, bus.err},  4'd1);
        chk("len0_cnt",  bus.cnt, 4'd2);
        next_cycle();

        // Mid-burst reset during the REQ cycle with rem=1.
        bus.start = 1'b1;
        bus.len   = 4'd3;
        next_cycle();
        bus.start = 1'b0;
        next_cycle();
        bus.s = 1'b1;
        next_cycle();
        bus.s = 1'b0;
        chk("pre_rst_do",  {3'b0, bus.do_o}, 4'd1);
        chk("pre_rst_cnt", bus.cnt, 4'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_do",   {3'b0, bus.do_o}, 4'd0);
        chk("midrst_busy", {3'b0, bus.busy}, 4'd0);
        chk("midrst_cnt",  bus.cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        run_burst(2, compliant(2), 1'b1, '0, 1'b0, 1'b0);

        // Randomized bursts.
        for (int r = 0; r < 40; r++) begin
            n  = int'($urandom_range(1, 15));
            sp = compliant(n);
            gp = '0;
            if ($urandom_range(0, 3) == 0) sp[$urandom_range(1, n + 2)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) gp[$urandom_range(1, n + 1)] = 1'b1;
            run_burst(n, sp, ($urandom_range(0, 5) != 0), gp,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
